sine_period_meter: RTL and testbench

- Receive side for the offset-binary sine sample stream produced by the team's sine generators.
- Detects rising mid-scale crossings using hysteresis.
- Measures the period in valid samples between consecutive rising crossings.
- Reports the maximum and minimum sample seen over each period. Sits downstream of a sine source or ADC capture and is used for frequency/amplitude self-check.

---
 rtl/sine_period_meter_if.sv | 25 ++
 rtl/sine_period_meter.sv | 118 +++++++++++
 tb/tb_sine_period_meter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_period_meter_if.sv
// Sample stream in, period/amplitude measurement out, for sine_period_meter.
// The source drives the master side; the meter sits on the slave side.
interface sine_period_meter_if #(
   parameter int N     = 7,
   parameter int CNT_W = 16
);
   logic [N:0]       sin_in;
   logic             sin_valid;
   logic [CNT_W-1:0] period;
   logic [N:0]       peak;
   logic [N:0]       trough;
   logic             meas_valid;
   logic             locked;
   logic             overflow;

   modport master (
      output sin_in, sin_valid,
      input  period, peak, trough, meas_valid, locked, overflow
   );

   modport slave (
      input  sin_in, sin_valid,
      output period, peak, trough, meas_valid, locked, overflow
   );
endinterface

// File: rtl/sine_period_meter.sv
// Rising mid-scale crossing detector with hysteresis; measures the period in
// valid samples and the peak/trough of each complete period.
module sine_period_meter #(
   parameter int N     = 7,
   parameter int CNT_W = 16,
   parameter int HYST  = 4
) (
   input  logic               clk,
   input  logic               rst,
   sine_period_meter_if.slave bus
);
   localparam int W = N + 1;
   localparam logic [N:0]       LO      = W'((2 ** N) - HYST);
   localparam logic [N:0]       HI      = W'((2 ** N) + HYST);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {SEEK, ARM, RUN_HI, RUN_LO} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [N:0]       run_max, run_min;
   logic             start, advance, measure, saturate;
   logic             low, high;

   function automatic logic [N:0] smax(input logic [N:0] a, input logic [N:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [N:0] smin(input logic [N:0] a, input logic [N:0] b);
      return (a < b) ? a : b;
   endfunction

   assign low  = (bus.sin_in <= LO);
   assign high = (bus.sin_in >= HI);

   always_ff @(posedge clk) begin
      if (rst) state <= SEEK;
      else     state <= state_n;
   end

   // Next state and datapath strobes; only valid samples can move anything.
   always_comb begin
      state_n  = state;
      start    = 1'b0;
      advance  = 1'b0;
      measure  = 1'b0;
      saturate = 1'b0;
      if (bus.sin_valid) begin
         unique case (state)
            SEEK: if (low) state_n = ARM;
            ARM: begin
               if (high) begin
                  start   = 1'b1;
                  state_n = RUN_HI;
               end
            end
            RUN_HI: begin
               if (cnt == CNT_MAX) begin
                  saturate = 1'b1;
                  state_n  = SEEK;
               end else begin
                  advance = 1'b1;
                  if (low) state_n = RUN_LO;
               end
            end
            RUN_LO: begin
               if (high) begin
                  measure = 1'b1;
                  start   = 1'b1;
                  state_n = RUN_HI;
               end else if (cnt == CNT_MAX) begin
                  saturate = 1'b1;
                  state_n  = SEEK;
               end else begin
                  advance = 1'b1;
               end
            end
            default: state_n = SEEK;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         run_max        <= '0;
         run_min        <= '1;
         bus.period     <= '0;
         bus.peak       <= '0;
         bus.trough     <= '1;
         bus.meas_valid <= 1'b0;
         bus.locked     <= 1'b0;
         bus.overflow   <= 1'b0;
      end else begin
         bus.meas_valid <= measure;
         if (measure) begin
            bus.period <= cnt;
            bus.peak   <= run_max;
            bus.trough <= run_min;
            bus.locked <= 1'b1;
         end
         if (saturate) begin
            bus.overflow <= 1'b1;
            bus.locked   <= 1'b0;
         end
         // The crossing sample opens the next period, so it seeds cnt and min/max.
         if (start) begin
            cnt     <= CNT_W'(1);
            run_max <= bus.sin_in;
            run_min <= bus.sin_in;
         end else if (advance) begin
            cnt     <= cnt + CNT_W'(1);
            run_max <= smax(run_max, bus.sin_in);
            run_min <= smin(run_min, bus.sin_in);
         end
      end
   end
endmodule

// File: tb/tb_sine_period_meter.sv
// Scoreboard bench for sine_period_meter: crossings push expected measurements,
// a negedge monitor pops and compares them when meas_valid fires.
module tb_sine_period_meter;
   localparam int N = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [N:0] sin_in = '0;
   logic       sin_valid = 1'b0;

   int tests_run = 0;
   int failed = 0;
   int ncyc = 0;
   bit sel8 = 1'b0;
   bit gap_mode = 1'b0;
   bit exp_ovf = 1'b0;

   typedef struct {
      int          cyc;
      logic [15:0] period;
      logic [7:0]  peak;
      logic [7:0]  trough;
   } exp_t;
   exp_t q[$];

   sine_period_meter_if #(.N(N), .CNT_W(16)) bus16 ();
   sine_period_meter_if #(.N(N), .CNT_W(8))  bus8 ();

   assign bus16.sin_in    = sin_in;
   assign bus16.sin_valid = sin_valid;
   assign bus8.sin_in     = sin_in;
   assign bus8.sin_valid  = sin_valid;

   sine_period_meter #(.N(N), .CNT_W(16), .HYST(4)) dut16 (
      .clk(clk), .rst(rst), .bus(bus16.slave)
   );
   sine_period_meter #(.N(N), .CNT_W(8), .HYST(4)) dut8 (
      .clk(clk), .rst(rst), .bus(bus8.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout tests_run=%0d", tests_run);
      $fatal(1, "timeout");
   end

   // Monitor on the falling edge, well away from the sampling edge.
   always @(negedge clk) begin
      logic        mv, lk, ov;
      logic [15:0] per;
      logic [7:0]  pk, tr;
      exp_t        e;
      ncyc++;
      mv  = sel8 ? bus8.meas_valid : bus16.meas_valid;
      per = sel8 ? {8'h00, bus8.period} : bus16.period;
      pk  = sel8 ? bus8.peak : bus16.peak;
      tr  = sel8 ? bus8.trough : bus16.trough;
      lk  = sel8 ? bus8.locked : bus16.locked;
      ov  = sel8 ? bus8.overflow : bus16.overflow;
      if (mv === 1'b1) begin
         tests_run++;
         if (q.size() == 0) begin
            failed++;
            $display("FAIL meas_unexpected cyc=%0d period=%0d peak=%h trough=%h", ncyc, per, pk, tr);
         end else begin
            e = q.pop_front();
            if (ncyc != e.cyc || per !== e.period || pk !== e.peak || tr !== e.trough ||
                lk !== 1'b1 || ov !== exp_ovf) begin
               failed++;
               $display("FAIL meas cyc got %0d want %0d, period got %0d want %0d, peak got %h want %h, trough got %h want %h, locked got %b want 1, overflow got %b want %b",
                        ncyc, e.cyc, per, e.period, pk, e.peak, tr, e.trough, lk, ov, exp_ovf);
            end
         end
      end else if (q.size() > 0 && ncyc >= q[0].cyc) begin
         tests_run++;
         failed++;
         $display("FAIL meas_missing at cyc %0d, want period %0d at cyc %0d", ncyc, q[0].period, q[0].cyc);
         void'(q.pop_front());
      end
   end

   task automatic send(input logic [7:0] s, input logic v);
      sin_in    = s;
      sin_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [7:0] s);
      send(s, 1'b1);
      if (gap_mode) send(8'($urandom_range(0, 255)), 1'b0);
   endtask

   // Output of the crossing edge is visible at the next falling edge.
   task automatic push(input int per);
      exp_t e;
      e.cyc    = ncyc + 1;
      e.period = 16'(per);
      e.peak   = 8'hC0;
      e.trough = 8'h40;
      q.push_back(e);
   endtask

   task automatic square(input int periods, input int first_meas);
      for (int p = 0; p < periods; p++) begin
         for (int i = 0; i < 64; i++) sample(8'h40);
         for (int i = 0; i < 64; i++) begin
            send(8'hC0, 1'b1);
            if (i == 0 && p >= first_meas) push(128);
            if (gap_mode) send(8'($urandom_range(0, 255)), 1'b0);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      send(8'h00, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(8'hFF, 1'(i % 2));
         tests_run++;
         if (bus16.meas_valid !== 1'b0 || bus8.meas_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_meas got %b/%b want 0/0", bus16.meas_valid, bus8.meas_valid);
         end
      end
      rst = 1'b0;
      tests_run++;
      if (bus16.period !== 16'h0 || bus16.peak !== 8'h00 || bus16.trough !== 8'hFF ||
          bus16.locked !== 1'b0 || bus16.overflow !== 1'b0) begin
         failed++;
         $display("FAIL reset_vals16 got period=%h peak=%h trough=%h locked=%b overflow=%b want 0 00 ff 0 0",
                  bus16.period, bus16.peak, bus16.trough, bus16.locked, bus16.overflow);
      end
      tests_run++;
      if (bus8.period !== 8'h0 || bus8.peak !== 8'h00 || bus8.trough !== 8'hFF ||
          bus8.locked !== 1'b0 || bus8.overflow !== 1'b0) begin
         failed++;
         $display("FAIL reset_vals8 got period=%h peak=%h trough=%h locked=%b overflow=%b want 0 00 ff 0 0",
                  bus8.period, bus8.peak, bus8.trough, bus8.locked, bus8.overflow);
      end
      // High samples straight out of reset must not be taken as a crossing.
      for (int i = 0; i < 5; i++) send(8'hFF, 1'b1);
   endtask

   task automatic test_square();
      do_reset();
      square(5, 1);
      tests_run++;
      if (bus16.locked !== 1'b1 || bus16.overflow !== 1'b0) begin
         failed++;
         $display("FAIL square_flags got locked=%b overflow=%b want 1 0", bus16.locked, bus16.overflow);
      end
   endtask

   task automatic test_hysteresis();
      for (int i = 0; i < 1000; i++) send((i % 2 == 0) ? 8'h7E : 8'h82, 1'b1);
      tests_run++;
      if (bus16.period !== 16'd128 || bus16.peak !== 8'hC0 || bus16.trough !== 8'h40 ||
          bus16.locked !== 1'b1) begin
         failed++;
         $display("FAIL hyst_hold got period=%0d peak=%h trough=%h locked=%b want 128 c0 40 1",
                  bus16.period, bus16.peak, bus16.trough, bus16.locked);
      end
      // Still in the high half: the open period spans 64 + 1000 + 64 samples.
      for (int i = 0; i < 64; i++) send(8'h40, 1'b1);
      send(8'hC0, 1'b1);
      push(1128);
      for (int i = 0; i < 63; i++) send(8'hC0, 1'b1);
   endtask

   task automatic test_valid_gaps();
      do_reset();
      gap_mode = 1'b1;
      square(4, 1);
      gap_mode = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      square(2, 1);
      for (int i = 0; i < 30; i++) send(8'h40, 1'b1);
      rst = 1'b1;
      send(8'h40, 1'b1);
      rst = 1'b0;
      tests_run++;
      if (bus16.period !== 16'd0 || bus16.locked !== 1'b0 || bus16.trough !== 8'hFF) begin
         failed++;
         $display("FAIL midrst_vals got period=%0d locked=%b trough=%h want 0 0 ff",
                  bus16.period, bus16.locked, bus16.trough);
      end
      square(3, 1);
   endtask

   task automatic test_overflow();
      sel8 = 1'b1;
      exp_ovf = 1'b0;
      do_reset();
      square(2, 1);
      for (int i = 0; i < 64; i++) send(8'h40, 1'b1);
      for (int i = 1; i <= 300; i++) begin
         send(8'hC0, 1'b1);
         if (i == 1) push(128);
         if (i == 255) begin
            tests_run++;
            if (bus8.overflow !== 1'b0 || bus8.locked !== 1'b1) begin
               failed++;
               $display("FAIL ovf_before got overflow=%b locked=%b want 0 1", bus8.overflow, bus8.locked);
            end
         end
         if (i == 256) begin
            tests_run++;
            if (bus8.overflow !== 1'b1 || bus8.locked !== 1'b0) begin
               failed++;
               $display("FAIL ovf_at got overflow=%b locked=%b want 1 0", bus8.overflow, bus8.locked);
            end
         end
      end
      tests_run++;
      if (bus8.overflow !== 1'b1 || bus8.locked !== 1'b0 || bus8.period !== 8'd128 ||
          bus8.peak !== 8'hC0 || bus8.trough !== 8'h40) begin
         failed++;
         $display("FAIL ovf_hold got overflow=%b locked=%b period=%0d peak=%h trough=%h want 1 0 128 c0 40",
                  bus8.overflow, bus8.locked, bus8.period, bus8.peak, bus8.trough);
      end
      exp_ovf = 1'b1;
      square(3, 1);
      tests_run++;
      if (bus8.overflow !== 1'b1 || bus8.locked !== 1'b1) begin
         failed++;
         $display("FAIL ovf_relock got overflow=%b locked=%b want 1 1", bus8.overflow, bus8.locked);
      end
   endtask

   initial begin
      test_reset();
      test_square();
      test_hysteresis();
      test_valid_gaps();
      test_reset_mid_run();
      test_overflow();
      for (int i = 0; i < 3; i++) send(8'h00, 1'b0);
      tests_run++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule
